uart_core_param: RTL and testbench

//  Parametrised full-duplex UART core: one TX and one RX engine sharing a runtime baud prescaler.

---
 rtl/uart_core_param.sv | 137 +++++++++++++
 tb/tb_uart_core_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART core with per-engine baud prescaler.
// Optional parity support is compiled in by defining UART_PARITY_EN.
module uart_core_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
`ifdef UART_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_req;
    assign par_req = PAR_BUILD && (parity_mode == 2'b01 || parity_mode == 2'b10);
    state_t tx_st, tx_nx;
    logic [DIV_W-1:0] tx_div, tx_pc;
    logic [TW-1:0] tx_tc;
    logic [BW-1:0] tx_bc;
    logic [DATA_BITS-1:0] tx_sh;
    logic tx_par, tx_pen, tx_tick, tx_bend;
    assign tx_tick = tx_pc == tx_div;
    assign tx_bend = tx_tick && tx_tc == T_LAST;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tx_st <= IDLE;
        else tx_st <= tx_nx;
    always_comb begin
        tx_nx = tx_st;
        case (tx_st)
            IDLE:    tx_nx = tx_valid ? START : IDLE;
            START:   tx_nx = tx_bend ? DATA : START;
            DATA:    tx_nx = tx_bend && tx_bc == D_LAST ? (tx_pen ? PARITY : STOP) : DATA;
            PARITY:  tx_nx = tx_bend ? STOP : PARITY;
            STOP:    tx_nx = tx_bend && tx_bc == S_LAST ? IDLE : STOP;
            default: tx_nx = IDLE;
        endcase
    end
    always_comb begin
        tx_ready = tx_st == IDLE;
        tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_par : 1'b1;
    end
    // Accept restarts the prescaler phase so every bit is exactly OVERSAMPLE*(div+1) clocks.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_div <= '0; tx_pc <= '0; tx_tc <= '0; tx_bc <= '0; tx_sh <= '0;
            tx_par <= 1'b0; tx_pen <= 1'b0; tx_done <= 1'b0;
        end else begin
            tx_done <= tx_st == STOP && tx_nx == IDLE;
            if (tx_st == IDLE) begin
                if (tx_valid) begin
                    tx_div <= baud_div; tx_pc <= '0; tx_tc <= '0; tx_bc <= '0; tx_sh <= tx_data;
                    tx_par <= ^tx_data ^ parity_mode[1]; tx_pen <= par_req;
                end
            end else begin
                tx_pc <= tx_tick ? '0 : tx_pc + 1'b1;
                if (tx_tick) tx_tc <= tx_tc == T_LAST ? '0 : tx_tc + 1'b1;
                if (tx_bend) begin
                    tx_bc <= tx_nx != tx_st ? '0 : tx_bc + 1'b1;
                    if (tx_st == DATA) tx_sh <= tx_sh >> 1;
                end
            end
        end
    logic [1:0] rx_sy;
    state_t rx_st, rx_nx;
    logic [DIV_W-1:0] rx_div, rx_pc;
    logic [TW-1:0] rx_tc;
    logic [BW-1:0] rx_bc;
    logic [DATA_BITS-1:0] rx_sh;
    logic rxs, rx_pen, rx_odd, rx_fe, rx_pe, rx_tick, rx_smp, rx_last, fe_now;
    assign rxs = rx_sy[1];
    assign rx_tick = rx_pc == rx_div;
    assign rx_smp = rx_tick && rx_tc == (rx_st == START ? T_MID : T_LAST);
    assign rx_last = rx_st == STOP && rx_smp && rx_bc == S_LAST;
    assign fe_now = rx_fe || !rxs;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rx_st <= IDLE;
        else rx_st <= rx_nx;
    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            IDLE:    rx_nx = rxs ? IDLE : START;
            START:   rx_nx = rx_smp ? (rxs ? IDLE : DATA) : START;
            DATA:    rx_nx = rx_smp && rx_bc == D_LAST ? (rx_pen ? PARITY : STOP) : DATA;
            PARITY:  rx_nx = rx_smp ? STOP : PARITY;
            STOP:    rx_nx = rx_last ? IDLE : STOP;
            default: rx_nx = IDLE;
        endcase
    end
    // Configuration is re-latched every idle cycle, so the value at the start edge sticks for the frame.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_sy <= 2'b11; rx_div <= '0; rx_pc <= '0; rx_tc <= '0; rx_bc <= '0; rx_sh <= '0;
            rx_pen <= 1'b0; rx_odd <= 1'b0; rx_fe <= 1'b0; rx_pe <= 1'b0; rx_data <= '0;
            rx_valid <= 1'b0; rx_frame_err <= 1'b0; rx_parity_err <= 1'b0;
        end else begin
            rx_sy <= {rx_sy[0], rx};
            rx_valid <= rx_last && !fe_now && !rx_pe;
            rx_frame_err <= rx_last && fe_now;
            rx_parity_err <= rx_last && !fe_now && rx_pe;
            if (rx_last && !fe_now) rx_data <= rx_sh;
            if (rx_st == IDLE) begin
                rx_div <= baud_div; rx_pc <= '0; rx_tc <= '0; rx_bc <= '0;
                rx_fe <= 1'b0; rx_pe <= 1'b0; rx_pen <= par_req; rx_odd <= parity_mode[1];
            end else begin
                rx_pc <= rx_tick ? '0 : rx_pc + 1'b1;
                if (rx_tick) rx_tc <= (rx_smp || rx_tc == T_LAST) ? '0 : rx_tc + 1'b1;
                if (rx_smp) begin
                    rx_bc <= rx_nx != rx_st ? '0 : rx_bc + 1'b1;
                    if (rx_st == DATA) rx_sh <= {rxs, rx_sh[DATA_BITS-1:1]};
                    if (rx_st == PARITY) rx_pe <= rxs ^ (^rx_sh) ^ rx_odd;
                    if (rx_st == STOP) rx_fe <= fe_now;
                end
            end
        end
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: scoreboarded bench for uart_core_param (loopback and directly driven RX frames).
module tb_uart_core_param;
    localparam int OS = 16;
    typedef logic bitq_t[$];
    typedef struct {int kind; logic [7:0] data;} exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [15:0] baud_div = '0;
    logic [1:0] parity_mode = '0;
    logic tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic tx_ready, tx, tx_done;
    logic loop = 1'b1, rx_drv = 1'b1, rx;
    logic [7:0] rx_data;
    logic rx_valid, rx_frame_err, rx_parity_err;
    int comps = 0, errs = 0;
    exp_t sb[$];
    logic [7:0] last_rx = '0;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_core_param dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx), .tx_done(tx_done),
        .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        comps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit par_active();
`ifdef UART_PARITY_EN
        return parity_mode == 2'b01 || parity_mode == 2'b10;
`else
        return 1'b0;
`endif
    endfunction

    // Line-level frame: start 0, data LSB first, optional parity, one stop bit.
    function automatic bitq_t frame(input logic [7:0] d, input bit flip_par, input logic stop_v);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par_active()) q.push_back((^d) ^ (parity_mode == 2'b10) ^ flip_par);
        q.push_back(stop_v);
        return q;
    endfunction

    // kind: 0 good frame, 1 frame error (data must stay at the last accepted value), 2 parity error
    task automatic expect_rx(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = kind == 1 ? last_rx : d;
        if (kind != 1) last_rx = d;
        sb.push_back(e);
    endtask

    always @(negedge clk)
        if (rst_n && (rx_valid || rx_frame_err || rx_parity_err)) begin
            exp_t e;
            chk("rx_one_pulse", $countones({rx_valid, rx_frame_err, rx_parity_err}), 1);
            if (sb.size() == 0) chk("rx_unexpected_pulse", {rx_frame_err, rx_parity_err, rx_valid}, 0);
            else begin
                e = sb.pop_front();
                chk("rx_kind", rx_frame_err ? 1 : rx_parity_err ? 2 : 0, e.kind);
                chk("rx_data", rx_data, e.data);
            end
        end

    task automatic send_frame(input logic [7:0] d, input logic [15:0] div);
        int L = OS * (int'(div) + 1);
        bitq_t bits = frame(d, 1'b0, 1'b1);
        @(negedge clk);
        chk("tx_ready_idle", tx_ready, 1);
        tx_data = d;
        baud_div = div;
        tx_valid = 1'b1;
        expect_rx(0, d);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = ~d;
        for (int c = 0; c < (bits.size() + 2) * L; c++) begin
            if (c > 0) @(negedge clk);
            if (tx_done) begin
                chk("tx_done_cycle", c, bits.size() * L);
                return;
            end
            if (c % L == L / 2 && c / L < bits.size()) chk("tx_bit", tx, bits[c / L]);
            if (c == L / 2) chk("tx_ready_busy", tx_ready, 0);
        end
        chk("tx_done_timeout", 0, 1);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic [15:0] div, input bit flip_par, input logic stop_v);
        int L = OS * (int'(div) + 1);
        bitq_t bits = frame(d, flip_par, stop_v);
        baud_div = div;
        @(negedge clk);
        foreach (bits[i]) begin
            rx_drv = bits[i];
            // a low stop bit is released soon after mid-bit so the line settles idle
            repeat ((i == bits.size() - 1 && !stop_v) ? L / 2 + 4 : L) @(negedge clk);
            rx_drv = 1'b1;
        end
        repeat (L) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_pulses", {tx_done, rx_valid, rx_frame_err, rx_parity_err}, 0);
        rst_n = 1'b1;
        send_frame(8'hA5, 16'd0);
        send_frame(8'h00, 16'd3);
        send_frame(8'hFF, 16'd3);
        send_frame(8'h5A, 16'd3);
        repeat (6) send_frame(8'($urandom_range(0, 255)), 16'($urandom_range(0, 3)));
        loop = 1'b0;
        baud_div = '0;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        expect_rx(0, 8'h3C);
        drive_rx(8'h3C, 16'd0, 1'b0, 1'b1);
        expect_rx(1, 8'h81);
        drive_rx(8'h81, 16'd0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("rx_data_after_frame_err", rx_data, 8'h3C);
`ifdef UART_PARITY_EN
        parity_mode = 2'b10;
        loop = 1'b1;
        send_frame(8'h01, 16'd0);
        loop = 1'b0;
        expect_rx(2, 8'h01);
        drive_rx(8'h01, 16'd0, 1'b1, 1'b1);
        parity_mode = 2'b00;
`endif
        loop = 1'b1;
        baud_div = '0;
        tx_data = 8'h99;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_frame_busy", tx_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_tx", tx, 1);
        chk("reset_mid_tx_ready", tx_ready, 1);
        chk("reset_mid_rx_data", rx_data, 0);
        last_rx = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h42, 16'd0);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end
endmodule
